mmu_ptw: RTL

MMU_PTW -- requirements
Module: mmu_ptw

---
 rtl/mmu_ptw.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mmu_ptw.sv
// mmu_ptw -- Sv32 hardware page-table walker.
//
// Walks the two-level Sv32 table on a TLB miss (or A/D update request),
// then either writes the resulting translation into the TLB or reports a
// page fault. One walk at a time; new requests are only accepted in IDLE.
//
// Optional feature macro: MMU_PTW_AD_UPDATE_EN
//   defined   : a leaf needing an Accessed/Dirty update is written back to
//               memory (WRAD state) and the updated PTE is filled.
//   undefined : such a leaf raises a page fault instead; no memory write.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_i, vir_addr_i, we_i    walk request, faulting VA, store access
//   req_upd_i, req_index_i     request comes from tlb_update + its hit index
//   root_ppn_i                 root page-table PPN
//   busy_o, done_o, fault_o    walk status; done_o is a 1-cycle pulse
//   mem_*                      single-beat memory master (req held to ack)
//   tlb_*                      TLB write port, pulsed with done_o on success
module mmu_ptw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] vir_addr_i,
  input  logic        we_i,
  input  logic        req_upd_i,
  input  logic [3:0]  req_index_i,
  input  logic [21:0] root_ppn_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [33:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        tlb_we_o,
  output logic [3:0]  tlb_index_o,
  output logic [31:0] tlb_vpn_o,
  output logic [31:0] tlb_mask_o,
  output logic [31:0] tlb_pte_o
);

  localparam logic [31:0] MASK_MEGA = 32'hFFC0_0000;
  localparam logic [31:0] MASK_4K   = 32'hFFFF_F000;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WRAD, RESP} state_t;

  state_t      state;
  logic [31:0] va_q;
  logic        we_q;
  logic        upd_q;
  logic [3:0]  idx_q;
  logic [3:0]  rr_q;
`ifdef MMU_PTW_AD_UPDATE_EN
  logic [31:0] pte_q;   // PTE with A/D set, filled after the write-back
  logic [31:0] mask_q;
  logic [31:0] ad_pte;
`endif

  // Decode of the PTE returned on this cycle's ack.
  logic        invalid, is_ptr, leaf_ok, descend, need_ad, go_wrad, resp_fault;
  logic [31:0] walk_mask, resp_mask, resp_pte;
  logic [33:0] l1_addr, l2_addr;

  assign l1_addr = {root_ppn_i, 12'h000} + {22'h0, vir_addr_i[31:22], 2'b00};
  assign l2_addr = {mem_rdata_i[31:10], 12'h000} + {22'h0, va_q[21:12], 2'b00};

  always_comb begin
    invalid   = !mem_rdata_i[0] || (!mem_rdata_i[1] && mem_rdata_i[2]);
    is_ptr    = !mem_rdata_i[1] && !mem_rdata_i[3];
    need_ad   = !mem_rdata_i[6] || (we_q && !mem_rdata_i[7]);
    walk_mask = (state == RD1) ? MASK_MEGA : MASK_4K;
    // A first-level leaf must be megapage aligned (PPN0 == 0); a
    // second-level pointer is always a fault.
    leaf_ok   = !invalid && !is_ptr &&
                ((state != RD1) || (mem_rdata_i[19:10] == 10'h0));
    descend   = (state == RD1) && !invalid && is_ptr;
`ifdef MMU_PTW_AD_UPDATE_EN
    ad_pte     = mem_rdata_i | 32'h40 | (we_q ? 32'h80 : 32'h0);
    go_wrad    = (state != WRAD) && leaf_ok && need_ad;
    resp_fault = (state == WRAD) ? 1'b0 : !leaf_ok;
    resp_pte   = (state == WRAD) ? pte_q : mem_rdata_i;
    resp_mask  = (state == WRAD) ? mask_q : walk_mask;
`else
    go_wrad    = 1'b0;
    resp_fault = !leaf_ok || need_ad;
    resp_pte   = mem_rdata_i;
    resp_mask  = walk_mask;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      va_q        <= '0;
      we_q        <= 1'b0;
      upd_q       <= 1'b0;
      idx_q       <= '0;
      rr_q        <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      tlb_we_o    <= 1'b0;
      tlb_index_o <= '0;
      tlb_vpn_o   <= '0;
      tlb_mask_o  <= '0;
      tlb_pte_o   <= '0;
`ifdef MMU_PTW_AD_UPDATE_EN
      pte_q       <= '0;
      mask_q      <= '0;
`endif
    end else begin
      // Pulse outputs default low.
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
      tlb_we_o    <= 1'b0;
      tlb_index_o <= '0;
      tlb_vpn_o   <= '0;
      tlb_mask_o  <= '0;
      tlb_pte_o   <= '0;
      case (state)
        IDLE: if (req_i) begin
          state      <= RD1;
          busy_o     <= 1'b1;
          va_q       <= vir_addr_i;
          we_q       <= we_i;
          upd_q      <= req_upd_i;
          idx_q      <= req_index_i;
          mem_req_o  <= 1'b1;
          mem_we_o   <= 1'b0;
          mem_addr_o <= l1_addr;
        end
        RD1, RD2, WRAD: if (mem_ack_i) begin
          if (descend) begin
            state      <= RD2;
            mem_addr_o <= l2_addr;
          end else if (go_wrad) begin
`ifdef MMU_PTW_AD_UPDATE_EN
            // Write back to the same PTE address, which mem_addr_o holds.
            state       <= WRAD;
            mem_we_o    <= 1'b1;
            mem_wdata_o <= ad_pte;
            pte_q       <= ad_pte;
            mask_q      <= walk_mask;
`endif
          end else begin
            state       <= RESP;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b1;
            fault_o     <= resp_fault;
            if (!resp_fault) begin
              tlb_we_o    <= 1'b1;
              tlb_index_o <= upd_q ? idx_q : rr_q;
              tlb_vpn_o   <= va_q & resp_mask;
              tlb_mask_o  <= resp_mask;
              tlb_pte_o   <= resp_pte;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          if (tlb_we_o && !upd_q) rr_q <= rr_q + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
